// File: rtl/nvram_upload.sv
// nvram_upload: streams SIZE bytes of a 16-bit memory to the host during an
// ioctl upload session, fetching one word per byte pair over a toggle
// request/acknowledge port.
//
// Ports
//   clk_sys       sole clock, rising edge
//   reset         synchronous, active-high
//   ioctl_upload  host upload session active (level)
//   ioctl_index   host file index, compared with INDEX at session start
//   ioctl_rd      one-cycle strobe: host consumed ioctl_din, advance a byte
//   ioctl_din     byte at the current pointer (8'hFF outside READY)
//   busy          high while a word fetch is outstanding (FETCH state)
//   overrun       sticky: ioctl_rd arrived while busy
//   done          one-cycle pulse when the pointer reaches SIZE
//   mem_req       toggle request; pending while mem_req != mem_ack
//   mem_ack       toggle acknowledge (same clock domain)
//   mem_a         word address of the pending request
//   mem_q         read data, valid in the cycle mem_ack equals mem_req
module nvram_upload #(
  parameter logic [7:0]  INDEX = 8'hFF,
  parameter int unsigned SIZE  = 2048,
  parameter logic [22:0] BASE  = 23'h0
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_upload,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_rd,
  output logic [7:0]  ioctl_din,
  output logic        busy,
  output logic        overrun,
  output logic        done,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic [22:0] mem_a,
  input  logic [15:0] mem_q
);

  localparam int unsigned   AW   = $clog2(SIZE + 1);
  localparam logic [AW-1:0] LAST = AW'(SIZE);

  typedef enum logic [2:0] {IDLE, FETCH, READY, DRAIN, END} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] ptr, ptr_nxt, ptr_inc, issue_ptr;
  logic [15:0]   buffer;
  logic          upload_d;
  logic          issued;   // the request of the current fetch has been sent
  logic          in_sync;
  logic          start;
  logic          issue;
  logic          latch;
  logic          ovr_set;

  // mem_req is deliberately outside reset so a request in flight across a
  // reset is never re-toggled; its power-up value is 0.
  logic          mem_req_r = 1'b0;

  assign in_sync = (mem_req_r == mem_ack);
  assign ptr_inc = ptr + 1'b1;
  // upload_d follows the input even during reset, so an edge seen during
  // reset is consumed and cannot start a session afterwards.
  assign start   = ioctl_upload && !upload_d && (ioctl_index == INDEX);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    issue     = 1'b0;
    issue_ptr = '0;
    latch     = 1'b0;
    ovr_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = FETCH;
          ptr_nxt   = '0;
          issue     = in_sync;
        end
      end
      FETCH: begin
        ovr_set = ioctl_rd;
        if (!ioctl_upload) begin
          state_nxt = DRAIN;
        end else if (in_sync) begin
          if (issued) begin
            latch     = 1'b1;
            state_nxt = READY;
          end else begin
            // a stale request has just completed: send ours now
            issue     = 1'b1;
            issue_ptr = ptr;
          end
        end
      end
      READY: begin
        if (!ioctl_upload) begin
          state_nxt = IDLE;
        end else if (ioctl_rd) begin
          ptr_nxt = ptr_inc;
          if (ptr_inc == LAST) begin
            state_nxt = END;
          end else if (!ptr_inc[0]) begin
            state_nxt = FETCH;
            issue     = in_sync;
            issue_ptr = ptr_inc;
          end
        end
      end
      DRAIN: begin
        if (in_sync) state_nxt = IDLE;
      end
      END: begin
        if (!ioctl_upload) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    upload_d <= ioctl_upload;
    if (reset) begin
      state   <= IDLE;
      ptr     <= '0;
      buffer  <= '0;
      overrun <= 1'b0;
      done    <= 1'b0;
      mem_a   <= '0;
      issued  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      done  <= (state_nxt == END) && (state != END);
      if (issue) begin
        mem_req_r <= ~mem_req_r;
        mem_a     <= BASE + 23'(issue_ptr >> 1);
      end
      if (latch) buffer <= mem_q;
      if (state == IDLE && start) overrun <= 1'b0;
      else if (ovr_set)           overrun <= 1'b1;
      issued <= issue || (issued && (state == FETCH || state == DRAIN) &&
                          (state_nxt == FETCH || state_nxt == DRAIN));
    end
  end

  assign mem_req   = mem_req_r;
  assign busy      = (state == FETCH);
  assign ioctl_din = (state == READY) ? (ptr[0] ? buffer[15:8] : buffer[7:0]) : 8'hFF;

endmodule

// File: tb/tb_nvram_upload.sv
// Testbench for nvram_upload: SIZE=4 instance, toggle-handshake memory model
// with programmable ack latency, directed scenarios plus randomized sessions
// checked against the expected little-endian byte stream of the memory words.
module tb_nvram_upload;

  localparam logic [22:0] BASE = 23'h000100;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_upload = 1'b0;
  logic [7:0]  ioctl_index = 8'hFF;
  logic        ioctl_rd = 1'b0;
  logic [7:0]  ioctl_din;
  logic        busy, overrun, done, mem_req;
  logic        mem_ack = 1'b0;
  logic [22:0] mem_a;
  logic [15:0] mem_q = '0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload #(.INDEX(8'hFF), .SIZE(4), .BASE(BASE)) dut (
    .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload),
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_din(ioctl_din),
    .busy(busy), .overrun(overrun), .done(done), .mem_req(mem_req),
    .mem_ack(mem_ack), .mem_a(mem_a), .mem_q(mem_q)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory: two words, ack ack_delay cycles after a request becomes pending
  logic [15:0] mem [2];
  int ack_delay = 3;
  bit ack_hold  = 1'b0;
  int ack_cnt   = 0;

  always @(posedge clk_sys) begin
    if (mem_req != mem_ack && !ack_hold) begin
      if (ack_cnt >= ack_delay - 1) begin
        mem_ack <= mem_req;
        mem_q   <= mem[1'(mem_a - BASE)];
        ack_cnt <= 0;
      end else begin
        ack_cnt <= ack_cnt + 1;
      end
    end
  end

  // toggle / done monitor; a toggle is only legal from an in-sync handshake
  logic req_d = 1'b0;
  logic ack_d = 1'b0;
  int toggles = 0;
  int done_cnt = 0;
  int dup_err = 0;

  always @(posedge clk_sys) begin
    req_d <= mem_req;
    ack_d <= mem_ack;
    if (mem_req != req_d) begin
      toggles <= toggles + 1;
      if (req_d != ack_d) dup_err <= dup_err + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic start_session(input logic [7:0] idx);
    @(negedge clk_sys);
    ioctl_index  = idx;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
  endtask

  task automatic end_session();
    ioctl_upload = 1'b0;
    repeat (2) @(negedge clk_sys);
  endtask

  task automatic read_byte(input int gap, output logic [7:0] b);
    int n = 0;
    repeat (gap) @(negedge clk_sys);
    while (busy && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("busy_timeout", 32'(n >= 100), 0);
    b = ioctl_din;
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
  endtask

  // reads the whole file after a matching session has been started
  task automatic run_reads(input string tag, input int gap_max, input int t0, input int d0);
    logic [7:0] exp_q [$];
    logic [7:0] b;
    exp_q = {mem[0][7:0], mem[0][15:8], mem[1][7:0], mem[1][15:8]};
    for (int i = 0; i < 4; i++) begin
      read_byte($urandom_range(gap_max, 0), b);
      check($sformatf("%s_byte%0d", tag, i), b, exp_q[i]);
    end
    repeat (2) @(negedge clk_sys);
    check($sformatf("%s_toggles", tag), toggles - t0, 2);
    check($sformatf("%s_done", tag), done_cnt - d0, 1);
    check($sformatf("%s_din_end", tag), ioctl_din, 8'hFF);
    // a read strobe in END changes nothing
    ioctl_rd = 1'b1;
    @(negedge clk_sys);
    ioctl_rd = 1'b0;
    repeat (2) @(negedge clk_sys);
    check($sformatf("%s_din_end_rd", tag), ioctl_din, 8'hFF);
    check($sformatf("%s_done_once", tag), done_cnt - d0, 1);
    end_session();
    check($sformatf("%s_din_idle", tag), ioctl_din, 8'hFF);
  endtask

  task automatic full_session(input string tag, input int gap_max, input bit inject_ovr);
    int t0 = toggles;
    int d0 = done_cnt;
    start_session(8'hFF);
    check($sformatf("%s_ovr_clr", tag), overrun, 0);
    if (inject_ovr) begin
      @(negedge clk_sys);
      ioctl_rd = 1'b1;
      @(negedge clk_sys);
      ioctl_rd = 1'b0;
      check($sformatf("%s_ovr_set", tag), overrun, 1);
      check($sformatf("%s_still_busy", tag), busy, 1);
    end
    run_reads(tag, gap_max, t0, d0);
    if (inject_ovr) check($sformatf("%s_ovr_sticky", tag), overrun, 1);
  endtask

  task automatic foreign_session(input string tag, input logic [7:0] idx);
    int t0 = toggles;
    int d0 = done_cnt;
    bit bad = 1'b0;
    start_session(idx);
    repeat (20) begin
      @(negedge clk_sys);
      if (ioctl_din !== 8'hFF || busy !== 1'b0) bad = 1'b1;
    end
    check($sformatf("%s_toggles", tag), toggles - t0, 0);
    check($sformatf("%s_done", tag), done_cnt - d0, 0);
    check($sformatf("%s_din_ff", tag), 32'(bad), 0);
    end_session();
  endtask

  initial begin
    int t0, d0;
    logic r;
    logic [7:0] idx;

    mem[0] = 16'hA1B2;
    mem[1] = 16'hC3D4;
    repeat (3) @(negedge clk_sys);
    check("rst_din", ioctl_din, 8'hFF);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_done", done, 0);
    check("rst_mem_a", mem_a, 0);
    check("rst_mem_req", mem_req, 0);
    reset = 1'b0;
    @(negedge clk_sys);

    // basic four-byte upload, 3-cycle ack
    ack_delay = 3;
    full_session("basic", 0, 1'b0);

    // non-matching index is ignored
    foreign_session("foreign", 8'h01);

    // read strobe during the second busy cycle of the first fetch
    full_session("ovr", 0, 1'b1);

    // upload dropped while a fetch is outstanding
    ack_delay = 5;
    t0 = toggles;
    d0 = done_cnt;
    start_session(8'hFF);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    @(negedge clk_sys);
    check("drain_pending", 32'(mem_req != mem_ack), 1);
    check("drain_busy", busy, 0);
    check("drain_din", ioctl_din, 8'hFF);
    repeat (10) @(negedge clk_sys);
    check("drain_toggles", toggles - t0, 1);
    check("drain_sync", 32'(mem_req == mem_ack), 1);
    check("drain_done", done_cnt - d0, 0);
    ack_delay = 3;
    full_session("after_drain", 1, 1'b0);

    // reset while a request is outstanding
    ack_hold  = 1'b1;
    ack_delay = 2;
    start_session(8'hFF);
    @(negedge clk_sys);
    ioctl_upload = 1'b0;
    reset = 1'b1;
    r = mem_req;
    @(negedge clk_sys);
    reset = 1'b0;
    check("rstp_keep_req", mem_req, r);
    check("rstp_pending", 32'(mem_req != mem_ack), 1);
    check("rstp_busy", busy, 0);
    check("rstp_din", ioctl_din, 8'hFF);
    t0 = toggles;
    d0 = done_cnt;
    ack_hold = 1'b0;
    ioctl_upload = 1'b1;
    @(negedge clk_sys);
    check("rstp_fetch", busy, 1);
    check("rstp_no_early_toggle", toggles - t0, 0);
    run_reads("rstp", 0, t0, d0);

    // randomized sessions
    for (int s = 0; s < 20; s++) begin
      mem[0] = 16'($urandom);
      mem[1] = 16'($urandom);
      ack_delay = $urandom_range(6, 1);
      if ($urandom_range(3, 0) == 0) begin
        idx = 8'($urandom_range(254, 0));
        foreign_session($sformatf("rnd%0d_foreign", s), idx);
      end else begin
        full_session($sformatf("rnd%0d", s), 3, 1'b0);
      end
    end

    check("no_dup_toggle", dup_err, 0);
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
